// File: rtl/lcd_ctrl.sv
// lcd_fifo: small generic FIFO for queued LCD writes, with registered pointers and count.
// Latency: a pushed entry is poppable from the next cycle; pop_dat is read combinationally from the head entry.
// Backpressure: push_rdy drops when full, unless a pop fires in the same cycle, so full-with-pop still accepts.
module lcd_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    output logic                     push_rdy,
    output logic                     pop_vld,
    input  logic                     pop_rdy,
    output logic [WIDTH-1:0]         pop_dat,
    output logic [$clog2(DEPTH):0]   nxt_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_fire;
    logic             pop_fire;

    assign pop_vld   = (count != '0);
    assign pop_fire  = pop_rdy && pop_vld;
    assign push_rdy  = (count != FULL_CNT) || pop_fire;
    assign push_fire = push_vld && push_rdy;
    assign pop_dat   = mem[rd_ptr];

    // Occupancy after this edge, used by the owner for registered status flags.
    always_comb begin
        nxt_count = count;
        case ({push_fire, pop_fire})
            2'b10:   nxt_count = count + 1'b1;
            2'b01:   nxt_count = count - 1'b1;
            default: nxt_count = count;
        endcase
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge i_clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + 1'b1;
            if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
            count <= nxt_count;
        end
    end
endmodule

// lcd_ctrl: HD44780 sequencer; runs power-on init, then replays queued {RS,byte} writes with panel timing.
// Latency: a write to an idle block enters SETUP next cycle; EN rises T_SETUP cycles later.
// Backpressure: none upstream; writes to a full FIFO are dropped and latch o_ovf (ON bit still updates).
module lcd_ctrl #(
    parameter int T_PWRON     = 750000,
    parameter int T_SETUP     = 3,
    parameter int T_EN        = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000,
    parameter int DEPTH       = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_full,
    output logic        o_ovf,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data
);
    localparam int CMAX = (T_PWRON > T_EXEC_LONG) ? T_PWRON : T_EXEC_LONG;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic       rs;
        logic [7:0] dat;
    } entry_t;

    typedef enum logic [2:0] {
        S_PWRON,
        S_IDLE,
        S_SETUP,
        S_EN,
        S_HOLD,
        S_EXEC
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            in_init, in_init_nxt;
    logic [1:0]      init_idx, init_idx_nxt;
    logic            issue;
    entry_t          issue_ent;
    logic            pop;
    logic            long_exec;
    entry_t          push_ent;
    entry_t          head_ent;
    logic            fifo_vld;
    logic            push_rdy;
    logic [AW:0]     nxt_count;
    logic            unused_wdata;

    // Fixed init program: 8-bit/2-line/5x8, display on, clear, entry mode increment.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h01;
            default: init_cmd = 8'h06;
        endcase
    endfunction

    assign push_ent.rs  = i_wdata[8];
    assign push_ent.dat = i_wdata[7:0];
    assign unused_wdata = ^i_wdata[30:9];
    assign o_lcd_rw     = 1'b0;

    // Clear and home (and the home alias 0x03) need the long execution wait.
    assign long_exec = !o_lcd_rs && (o_lcd_data == 8'h01 || o_lcd_data == 8'h02 || o_lcd_data == 8'h03);

    lcd_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .push_vld  (i_wr),
        .push_dat  (push_ent),
        .push_rdy  (push_rdy),
        .pop_vld   (fifo_vld),
        .pop_rdy   (pop),
        .pop_dat   (head_ent),
        .nxt_count (nxt_count)
    );

    // Next-state, counter reload, and transaction issue decisions.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        in_init_nxt  = in_init;
        init_idx_nxt = init_idx;
        issue        = 1'b0;
        issue_ent    = '0;
        pop          = 1'b0;
        case (state)
            S_PWRON: begin
                if (cnt == '0) begin
                    state_nxt     = S_SETUP;
                    cnt_nxt       = CW'(T_SETUP - 1);
                    in_init_nxt   = 1'b1;
                    init_idx_nxt  = 2'd0;
                    issue         = 1'b1;
                    issue_ent.dat = init_cmd(2'd0);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_IDLE: begin
                if (fifo_vld) begin
                    pop       = 1'b1;
                    issue     = 1'b1;
                    issue_ent = head_ent;
                    state_nxt = S_SETUP;
                    cnt_nxt   = CW'(T_SETUP - 1);
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    state_nxt = S_EN;
                    cnt_nxt   = CW'(T_EN - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_EN: begin
                if (cnt == '0) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = CW'(T_HOLD - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    state_nxt = S_EXEC;
                    cnt_nxt   = long_exec ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_EXEC: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (in_init && init_idx != 2'd3) begin
                    init_idx_nxt  = init_idx + 1'b1;
                    issue         = 1'b1;
                    issue_ent.dat = init_cmd(init_idx + 1'b1);
                    state_nxt     = S_SETUP;
                    cnt_nxt       = CW'(T_SETUP - 1);
                end else if (in_init) begin
                    in_init_nxt = 1'b0;
                    state_nxt   = S_IDLE;
                end else if (fifo_vld) begin
                    pop       = 1'b1;
                    issue     = 1'b1;
                    issue_ent = head_ent;
                    state_nxt = S_SETUP;
                    cnt_nxt   = CW'(T_SETUP - 1);
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counter, pins and status flags; all outputs are registered.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= S_PWRON;
            cnt        <= CW'(T_PWRON);
            in_init    <= 1'b0;
            init_idx   <= 2'd0;
            o_lcd_en   <= 1'b0;
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= 8'h00;
            o_lcd_on   <= 1'b1;
            o_busy     <= 1'b1;
            o_full     <= 1'b0;
            o_ovf      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            in_init  <= in_init_nxt;
            init_idx <= init_idx_nxt;
            o_lcd_en <= (state_nxt == S_EN);
            if (issue) begin
                o_lcd_rs   <= issue_ent.rs;
                o_lcd_data <= issue_ent.dat;
            end
            if (i_wr) begin
                o_lcd_on <= i_wdata[31];
            end
            if (i_wr && !push_rdy) begin
                o_ovf <= 1'b1;
            end
            o_busy <= (state_nxt != S_IDLE) || (nxt_count != '0);
            o_full <= (nxt_count == FULL_CNT);
        end
    end
endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: expected EN pulses are queued as writes are driven and matched on each EN rise.
// Cycle numbering: cyc is the index of the last edge sampled with reset low (first such edge is 0).
// Inputs change 2 time units after an edge; outputs are read there too.
module tb_lcd_ctrl;
    localparam int T_PWRON     = 10;
    localparam int T_SETUP     = 2;
    localparam int T_EN        = 3;
    localparam int T_HOLD      = 1;
    localparam int T_EXEC      = 5;
    localparam int T_EXEC_LONG = 20;
    localparam int DEPTH       = 4;
    localparam int TXN         = T_SETUP + T_EN + T_HOLD + T_EXEC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic        busy, full, ovf, lcd_on, lcd_en, lcd_rs, lcd_rw;
    logic [7:0]  lcd_data;

    typedef struct {
        int         rise;
        logic       rs;
        logic [7:0] dat;
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = -1;
    int   last_rise = 0;
    logic prev_en = 1'b0;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .T_PWRON(T_PWRON), .T_SETUP(T_SETUP), .T_EN(T_EN), .T_HOLD(T_HOLD),
        .T_EXEC(T_EXEC), .T_EXEC_LONG(T_EXEC_LONG), .DEPTH(DEPTH)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_wdata(wdata),
        .o_busy(busy), .o_full(full), .o_ovf(ovf), .o_lcd_on(lcd_on),
        .o_lcd_en(lcd_en), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw), .o_lcd_data(lcd_data)
    );

    // Scoreboard monitor: each EN rise pops the oldest expectation; each fall checks the pulse width.
    always @(posedge clk) begin : monitor
        logic rst_at_edge;
        ev_t  e;
        rst_at_edge = rst;
        #1;
        if (rst_at_edge) cyc = -1;
        else cyc = cyc + 1;
        if (!rst_at_edge && lcd_en && !prev_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL en_rise_unexpected got cyc=%0d rs=%0b data=%02h expected no pulse", cyc, lcd_rs, lcd_data);
            end else begin
                e = exp_q.pop_front();
                if (cyc !== e.rise || lcd_rs !== e.rs || lcd_data !== e.dat) begin
                    errors++;
                    $display("FAIL en_rise got cyc=%0d rs=%0b data=%02h expected cyc=%0d rs=%0b data=%02h",
                             cyc, lcd_rs, lcd_data, e.rise, e.rs, e.dat);
                end
            end
            last_rise = cyc;
        end
        if (!rst_at_edge && !lcd_en && prev_en) begin
            checks++;
            if (cyc !== last_rise + T_EN) begin
                errors++;
                $display("FAIL en_width got fall at cyc=%0d expected cyc=%0d", cyc, last_rise + T_EN);
            end
        end
        prev_en = lcd_en;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic tick_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push_init_exp();
        exp_q.push_back('{rise: 12, rs: 1'b0, dat: 8'h38});
        exp_q.push_back('{rise: 23, rs: 1'b0, dat: 8'h0C});
        exp_q.push_back('{rise: 34, rs: 1'b0, dat: 8'h01});
        exp_q.push_back('{rise: 60, rs: 1'b0, dat: 8'h06});
    endtask

    task automatic reset_dut();
        rst   = 1'b1;
        wr    = 1'b0;
        wdata = 32'h0;
        tick();
        tick();
        exp_q.delete();
        push_init_exp();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (lcd_en !== 1'b0)     begin errors++; $display("FAIL rst_en got %0b want 0", lcd_en); end
        checks++; if (lcd_rs !== 1'b0)     begin errors++; $display("FAIL rst_rs got %0b want 0", lcd_rs); end
        checks++; if (lcd_rw !== 1'b0)     begin errors++; $display("FAIL rst_rw got %0b want 0", lcd_rw); end
        checks++; if (lcd_data !== 8'h00)  begin errors++; $display("FAIL rst_data got %02h want 00", lcd_data); end
        checks++; if (lcd_on !== 1'b1)     begin errors++; $display("FAIL rst_on got %0b want 1", lcd_on); end
        checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL rst_busy got %0b want 1", busy); end
        checks++; if (full !== 1'b0)       begin errors++; $display("FAIL rst_full got %0b want 0", full); end
        checks++; if (ovf !== 1'b0)        begin errors++; $display("FAIL rst_ovf got %0b want 0", ovf); end
    endtask

    task automatic test_init();
        reset_dut();
        tick_until(68);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL init_busy_c68 got %0b want 1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_busy_c69 got %0b want 0", busy); end
        checks++; if (lcd_data !== 8'h06 || lcd_rs !== 1'b0)
            begin errors++; $display("FAIL init_pins_hold got rs=%0b data=%02h want rs=0 data=06", lcd_rs, lcd_data); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL init_pending got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_single_write();
        reset_dut();
        tick_until(75);
        wr = 1'b1; wdata = 32'h0000_0141;
        exp_q.push_back('{rise: 79, rs: 1'b1, dat: 8'h41});
        tick();
        wr = 1'b0;
        tick();
        checks++; if (lcd_rs !== 1'b1 || lcd_data !== 8'h41)
            begin errors++; $display("FAIL single_pins got rs=%0b data=%02h want rs=1 data=41", lcd_rs, lcd_data); end
        tick_until(87);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_t11 got %0b want 1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_t12 got %0b want 0", busy); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_pending got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_clear();
        reset_dut();
        tick_until(75);
        wr = 1'b1; wdata = 32'h0000_0001;
        exp_q.push_back('{rise: 79, rs: 1'b0, dat: 8'h01});
        tick();
        wdata = 32'h0000_0142;
        exp_q.push_back('{rise: 79 + T_SETUP + T_EN + T_HOLD + T_EXEC_LONG, rs: 1'b1, dat: 8'h42});
        tick();
        wr = 1'b0;
        tick_until(102);
        checks++; if (lcd_data !== 8'h01) begin errors++; $display("FAIL clear_exec_data got %02h want 01", lcd_data); end
        tick();
        checks++; if (lcd_data !== 8'h42) begin errors++; $display("FAIL clear_next_setup got %02h want 42", lcd_data); end
        tick_until(120);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy_end got %0b want 0", busy); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL clear_pending got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_overflow_on();
        reset_dut();
        tick_until(19);
        for (int k = 0; k < 5; k++) begin
            wr    = 1'b1;
            wdata = (k < 4) ? (32'h8000_0161 + 32'(k)) : 32'h0000_0165;
            if (k < 4) exp_q.push_back('{rise: 72 + TXN * k, rs: 1'b1, dat: 8'(8'h61 + k)});
            tick();
            if (k == 3) begin
                checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full_4th got %0b want 1", full); end
                checks++; if (ovf !== 1'b0)  begin errors++; $display("FAIL ovf_early got %0b want 0", ovf); end
                checks++; if (lcd_on !== 1'b1) begin errors++; $display("FAIL on_bit_set got %0b want 1", lcd_on); end
            end
        end
        wr = 1'b0;
        checks++; if (ovf !== 1'b1)    begin errors++; $display("FAIL ovf_set got %0b want 1", ovf); end
        checks++; if (lcd_on !== 1'b0) begin errors++; $display("FAIL on_bit_dropped got %0b want 0", lcd_on); end
        checks++; if (full !== 1'b1)   begin errors++; $display("FAIL ovf_full_5th got %0b want 1", full); end
        tick_until(125);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", ovf); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_pending got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_full_pop();
        reset_dut();
        tick_until(19);
        for (int k = 0; k < 4; k++) begin
            wr    = 1'b1;
            wdata = 32'h0000_0131 + 32'(k);
            exp_q.push_back('{rise: 72 + TXN * k, rs: 1'b1, dat: 8'(8'h31 + k)});
            tick();
        end
        wr = 1'b0;
        tick_until(69);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fpop_full_before got %0b want 1", full); end
        wr = 1'b1; wdata = 32'h0000_0135;
        exp_q.push_back('{rise: 72 + TXN * 4, rs: 1'b1, dat: 8'h35});
        tick();
        wr = 1'b0;
        checks++; if (ovf !== 1'b0)  begin errors++; $display("FAIL fpop_ovf got %0b want 0", ovf); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fpop_full_after got %0b want 1", full); end
        tick_until(130);
        checks++; if (busy !== 1'b0 || full !== 1'b0)
            begin errors++; $display("FAIL fpop_idle got busy=%0b full=%0b want busy=0 full=0", busy, full); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fpop_pending got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        tick_until(75);
        wr = 1'b1; wdata = 32'h0000_0141;
        exp_q.push_back('{rise: 79, rs: 1'b1, dat: 8'h41});
        tick();
        wdata = 32'h0000_0142;
        tick();
        wr = 1'b0;
        tick_until(80);
        checks++; if (lcd_en !== 1'b1) begin errors++; $display("FAIL rmid_en_high got %0b want 1", lcd_en); end
        rst = 1'b1;
        tick();
        checks++; if (lcd_en !== 1'b0 || lcd_data !== 8'h00 || lcd_rs !== 1'b0 || busy !== 1'b1)
            begin errors++; $display("FAIL rmid_reset got en=%0b data=%02h rs=%0b busy=%0b want en=0 data=00 rs=0 busy=1",
                                     lcd_en, lcd_data, lcd_rs, busy); end
        exp_q.delete();
        push_init_exp();
        rst = 1'b0;
        tick_until(68);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_c68 got %0b want 1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy_c69 got %0b want 0", busy); end
        tick_until(100);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_pending got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_single_write();
        test_clear();
        test_overflow_on();
        test_full_pop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
